// File: rtl/i2c_cfg_sched.sv
// rtl/i2c_cfg_sched.sv - sequences two I2C register LUTs through a shared byte-write engine
// Each entry is retried up to MAX_RETRY times; the failing table/index is reported on give-up.
module i2c_cfg_sched #(
  parameter int          IDX_W     = 10,
  parameter int          MAX_RETRY = 3,
  parameter logic [15:0] GAP_CYC   = 16'd100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             tbl0_en,
  input  logic             tbl1_en,
  input  logic [IDX_W-1:0] tbl0_len,
  input  logic [IDX_W-1:0] tbl1_len,
  output logic [IDX_W-1:0] lut_index,
  input  logic [31:0]      lut0_data,
  input  logic [31:0]      lut1_data,
  output logic             wr_req,
  input  logic             wr_ack,
  output logic [7:0]       wr_dev,
  output logic [15:0]      wr_reg,
  output logic [7:0]       wr_data,
  input  logic             wr_done,
  input  logic             wr_err,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             err_tbl,
  output logic [IDX_W-1:0] err_idx
);
  localparam int            RW        = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, LOAD, REQ, WAIT, GAP, NEXT, FIN, FAIL} state_t;

  state_t           state;
  logic             tbl_sel;
  logic             en1_q;
  logic [IDX_W-1:0] len0_q;
  logic [IDX_W-1:0] len1_q;
  logic [RW-1:0]    retry_cnt;
  logic             retry_pend;
  logic [15:0]      gap_cnt;

  logic [IDX_W:0]   idx_nxt;
  logic             gap_last;
  logic             t1_ok;
  logic             comp_ev;
  logic [31:0]      lut_sel;

  // One extra bit so an index of 2^IDX_W-1 still compares against the length without wrapping
  assign idx_nxt  = {1'b0, lut_index} + (IDX_W+1)'(1);
  assign gap_last = ({1'b0, gap_cnt} + 17'd1) >= {1'b0, GAP_CYC};
  assign t1_ok    = en1_q && (len1_q != '0);
  assign lut_sel  = tbl_sel ? lut1_data : lut0_data;
  // A completion arriving together with the ack is handled as ack-then-completion
  assign comp_ev  = (state == WAIT || (state == REQ && wr_ack)) && (wr_done || wr_err);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tbl_sel    <= 1'b0;
      en1_q      <= 1'b0;
      len0_q     <= '0;
      len1_q     <= '0;
      retry_cnt  <= '0;
      retry_pend <= 1'b0;
      gap_cnt    <= '0;
      lut_index  <= '0;
      wr_req     <= 1'b0;
      wr_dev     <= '0;
      wr_reg     <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_tbl    <= 1'b0;
      err_idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len0_q     <= tbl0_len;
            len1_q     <= tbl1_len;
            en1_q      <= tbl1_en;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            err_tbl    <= 1'b0;
            err_idx    <= '0;
            lut_index  <= '0;
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
            if (tbl0_en && tbl0_len != '0) begin
              tbl_sel <= 1'b0;
              state   <= LOAD;
            end else if (tbl1_en && tbl1_len != '0) begin
              tbl_sel <= 1'b1;
              state   <= LOAD;
            end else begin
              state <= FIN;
            end
          end
        end
        LOAD: begin
          {wr_dev, wr_reg, wr_data} <= lut_sel;
          wr_req <= 1'b1;
          state  <= REQ;
        end
        REQ, WAIT: begin
          if (state == REQ && wr_ack) begin
            wr_req <= 1'b0;
            state  <= WAIT;
          end
          if (comp_ev) begin
            gap_cnt <= '0;
            if (wr_err) begin
              if (retry_cnt < RETRY_LIM) begin
                retry_cnt  <= retry_cnt + 1'b1;
                retry_pend <= 1'b1;
                state      <= GAP;
              end else begin
                state <= FAIL;
              end
            end else begin
              retry_cnt  <= '0;
              retry_pend <= 1'b0;
              state      <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_last) begin
            gap_cnt <= '0;
            if (retry_pend) begin
              retry_pend <= 1'b0;
              wr_req     <= 1'b1;
              state      <= REQ;
            end else begin
              state <= NEXT;
            end
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        NEXT: begin
          if (!tbl_sel && idx_nxt == {1'b0, len0_q}) begin
            if (t1_ok) begin
              tbl_sel   <= 1'b1;
              lut_index <= '0;
              state     <= LOAD;
            end else begin
              state <= FIN;
            end
          end else if (tbl_sel && idx_nxt == {1'b0, len1_q}) begin
            state <= FIN;
          end else begin
            lut_index <= idx_nxt[IDX_W-1:0];
            state     <= LOAD;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        FAIL: begin
          error   <= 1'b1;
          busy    <= 1'b0;
          err_tbl <= tbl_sel;
          err_idx <= lut_index;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/i2c_cfg_sched.md
I2C_CFG_SCHED -- requirements
Module: i2c_cfg_sched

Interface
REQ-001 The block SHALL have parameter IDX_W, default 10, giving the LUT index width.
REQ-002 The block SHALL have parameter MAX_RETRY, default 3, giving the retries per entry after a failed write.
REQ-003 The block SHALL have parameter GAP_CYC, default 16'd100, giving the idle clocks between consecutive writes.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle pulse that launches a configuration run.
REQ-007 The block SHALL have ports tbl0_en and tbl1_en, each input, 1 bit: enable table 0 (video-in receiver) and table 1 (video-out transmitter).
REQ-008 The block SHALL have ports tbl0_len and tbl1_len, each input, IDX_W bits: entry count per table, sampled at start.
REQ-009 The block SHALL have port lut_index, output, IDX_W bits: index presented to both LUTs.
REQ-010 The block SHALL have ports lut0_data and lut1_data, each input, 32 bits: {dev[31:24], reg[23:8], data[7:0]}, combinational from lut_index.
REQ-011 The block SHALL have port wr_req, output, 1 bit: write request to the shared I2C byte-write engine.
REQ-012 The block SHALL have port wr_ack, input, 1 bit: engine accepted the request.
REQ-013 The block SHALL have ports wr_dev (8 bits), wr_reg (16 bits) and wr_data (8 bits), all outputs: the latched entry fields.
REQ-014 The block SHALL have ports wr_done and wr_err, each input, 1 bit: one-cycle completion pulses, where wr_err means NACK or timeout.
REQ-015 The block SHALL have ports busy, done and error, each output, 1 bit: run status.
REQ-016 The block SHALL have ports err_tbl (output, 1 bit) and err_idx (output, IDX_W bits): the failing table and entry.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, REQ, WAIT, GAP, NEXT, FIN and FAIL.
REQ-018 In IDLE, a start pulse SHALL latch the lengths and enables, set busy, clear done, error and err_*, and select the first enabled, non-empty table with lut_index=0.
REQ-019 If no table is enabled and non-empty, start SHALL go directly to FIN, giving done=1 two cycles after start.
REQ-020 LOAD SHALL take one cycle and register lutN_data of the selected table into wr_dev, wr_reg and wr_data.
REQ-021 In REQ, wr_req SHALL be held high until the cycle in which wr_ack=1, and SHALL then drop on the next cycle.
REQ-022 In REQ, wr_dev, wr_reg and wr_data SHALL remain stable.
REQ-023 In WAIT, wr_done SHALL go to GAP with the retry count cleared.
REQ-024 In WAIT, wr_err with retries<MAX_RETRY SHALL increment the retry count and go to GAP, then re-issue the same entry without reloading it.
REQ-025 In WAIT, wr_err with retries=MAX_RETRY SHALL go to FAIL.
REQ-026 If wr_done and wr_err are asserted in the same cycle, the event SHALL be treated as wr_err.
REQ-027 If wr_ack and wr_done are asserted in the same cycle, the event SHALL be treated as ack followed by done, advancing to GAP next cycle.
REQ-028 GAP SHALL count GAP_CYC clocks and then go to NEXT, or to REQ if a retry is pending.
REQ-029 If GAP_CYC=0, GAP SHALL last exactly one cycle.
REQ-030 In NEXT, lut_index SHALL increment, and if the new index equals the table length, the block SHALL switch to table 1 (if enabled and non-empty) with index 0, else go to FIN.
REQ-031 Table 0 SHALL always be sequenced before table 1.
REQ-032 The lut_index increment SHALL be computed at IDX_W+1 bits, so that a length of 2^IDX_W-1 terminates correctly.
REQ-033 FIN SHALL set done=1 and busy=0 and return to IDLE.
REQ-034 FAIL SHALL set error=1, busy=0, err_tbl and err_idx, and return to IDLE.
REQ-035 done, error and err_* SHALL be sticky until the next accepted start or reset.
REQ-036 A start pulse SHALL be ignored while busy=1.
REQ-037 Inputs wr_done and wr_err SHALL be ignored outside WAIT.
REQ-038 Each run SHALL issue at most (len0+len1)*(MAX_RETRY+1) wr_req handshakes.

Reset
REQ-039 Reset SHALL take effect on the clk edge and SHALL be valid in any state, including with wr_req high mid-transaction.
REQ-040 Reset SHALL return the FSM to IDLE with wr_req=0, busy=0, done=0, error=0, lut_index=0, wr_dev/wr_reg/wr_data=0, err_tbl=0, err_idx=0, and retry and gap counters at 0.
REQ-041 After reset, the block SHALL require a new start pulse; it SHALL NOT resume the previous run.

Verification
REQ-042 Nominal run: tbl0_len=3, tbl1_len=2, both enabled, engine acks in 1 cycle and done after 20 cycles -> five writes in order T0[0..2] then T1[0..1], fields matching the LUTs, writes spaced by at least GAP_CYC, then done=1, error=0.
REQ-043 Retry then success: T0 entry 1 returns wr_err twice, then wr_done -> entry 1 is issued three times with identical fields, the run completes, done=1.
REQ-044 Retry exhaustion: T1 entry 0 always returns wr_err -> four attempts, then error=1, err_tbl=1, err_idx=0, done=0, and no further wr_req.
REQ-045 Skipped tables: tbl0_en=0 with tbl1_len=1 -> exactly one write from table 1; tbl0_len=tbl1_len=0 -> done=1 two cycles after start with no wr_req.
REQ-046 Delayed ack and start while busy: wr_ack held low for 50 cycles -> wr_req stays high with stable fields for 50 cycles; a start pulse in this window is ignored.
REQ-047 Simultaneous events and reset: wr_done together with wr_err -> counted as a retry; rst asserted during WAIT -> all outputs at reset values on the next cycle.
